// File: rtl/rsvs_issue.sv
// Reservation-station issue queue: buffers dispatched micro-ops, wakes sources from the CDB,
// and issues the lowest-index ready entry through a registered valid/ready issue stage.
module rsvs_issue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     disp_valid,
  output logic                     disp_ready,
  input  logic [4:0]               disp_opcode,
  input  logic [2:0]               disp_branch_type,
  input  logic [TAG_W-1:0]         disp_rob_tag,
  input  logic                     disp_rs1_rdy,
  input  logic                     disp_rs2_rdy,
  input  logic [TAG_W-1:0]         disp_rs1_tag,
  input  logic [TAG_W-1:0]         disp_rs2_tag,
  input  logic [XLEN-1:0]          disp_rs1_val,
  input  logic [XLEN-1:0]          disp_rs2_val,
  input  logic                     cdb_valid,
  input  logic [TAG_W-1:0]         cdb_tag,
  input  logic [XLEN-1:0]          cdb_data,
  output logic                     iss_valid,
  input  logic                     iss_ready,
  output logic [4:0]               iss_opcode,
  output logic [2:0]               iss_branch_type,
  output logic [XLEN-1:0]          iss_rs1,
  output logic [XLEN-1:0]          iss_rs2,
  output logic [TAG_W-1:0]         iss_rob_tag,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] rs1_rdy_q, rs1_rdy_d;
  logic [DEPTH-1:0] rs2_rdy_q, rs2_rdy_d;
  logic [4:0]       opcode_q [DEPTH];
  logic [4:0]       opcode_d [DEPTH];
  logic [2:0]       btype_q  [DEPTH];
  logic [2:0]       btype_d  [DEPTH];
  logic [TAG_W-1:0] rob_q    [DEPTH];
  logic [TAG_W-1:0] rob_d    [DEPTH];
  logic [TAG_W-1:0] rs1_tag_q [DEPTH];
  logic [TAG_W-1:0] rs1_tag_d [DEPTH];
  logic [TAG_W-1:0] rs2_tag_q [DEPTH];
  logic [TAG_W-1:0] rs2_tag_d [DEPTH];
  logic [XLEN-1:0]  rs1_val_q [DEPTH];
  logic [XLEN-1:0]  rs1_val_d [DEPTH];
  logic [XLEN-1:0]  rs2_val_q [DEPTH];
  logic [XLEN-1:0]  rs2_val_d [DEPTH];

  logic [CNT_W-1:0] count_q, count_d;
  logic             iss_valid_q, iss_valid_d;
  logic [4:0]       iss_opcode_q, iss_opcode_d;
  logic [2:0]       iss_btype_q, iss_btype_d;
  logic [XLEN-1:0]  iss_rs1_q, iss_rs1_d;
  logic [XLEN-1:0]  iss_rs2_q, iss_rs2_d;
  logic [TAG_W-1:0] iss_rob_q, iss_rob_d;

  logic             sel_found, alloc_found;
  logic [IDX_W-1:0] sel_idx, alloc_idx;
  logic             accept, load, move;
  logic             byp1, byp2;

  assign disp_ready = (count_q != CNT_W'(DEPTH));

  // Priority encoders: lowest-index ready entry and lowest-index free entry.
  always_comb begin
    sel_found   = 1'b0;
    sel_idx     = '0;
    alloc_found = 1'b0;
    alloc_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!sel_found && valid_q[i] && rs1_rdy_q[i] && rs2_rdy_q[i]) begin
        sel_found = 1'b1;
        sel_idx   = i[IDX_W-1:0];
      end
      if (!alloc_found && !valid_q[i]) begin
        alloc_found = 1'b1;
        alloc_idx   = i[IDX_W-1:0];
      end
    end
  end

  assign accept = disp_valid & disp_ready & alloc_found & ~flush;
  assign load   = (~iss_valid_q | iss_ready) & ~flush;
  assign move   = load & sel_found;
  assign byp1   = ~disp_rs1_rdy & cdb_valid & (cdb_tag == disp_rs1_tag);
  assign byp2   = ~disp_rs2_rdy & cdb_valid & (cdb_tag == disp_rs2_tag);

  always_comb begin
    valid_d   = valid_q;
    rs1_rdy_d = rs1_rdy_q;
    rs2_rdy_d = rs2_rdy_q;
    opcode_d  = opcode_q;
    btype_d   = btype_q;
    rob_d     = rob_q;
    rs1_tag_d = rs1_tag_q;
    rs2_tag_d = rs2_tag_q;
    rs1_val_d = rs1_val_q;
    rs2_val_d = rs2_val_q;

    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && !rs1_rdy_q[i] && cdb_valid && (cdb_tag == rs1_tag_q[i])) begin
        rs1_rdy_d[i] = 1'b1;
        rs1_val_d[i] = cdb_data;
      end
      if (valid_q[i] && !rs2_rdy_q[i] && cdb_valid && (cdb_tag == rs2_tag_q[i])) begin
        rs2_rdy_d[i] = 1'b1;
        rs2_val_d[i] = cdb_data;
      end
    end

    if (move) begin
      valid_d[sel_idx] = 1'b0;
    end

    // The freed entry is still valid this cycle, so allocation never collides with a move.
    if (accept) begin
      valid_d[alloc_idx]   = 1'b1;
      opcode_d[alloc_idx]  = disp_opcode;
      btype_d[alloc_idx]   = disp_branch_type;
      rob_d[alloc_idx]     = disp_rob_tag;
      rs1_tag_d[alloc_idx] = disp_rs1_tag;
      rs2_tag_d[alloc_idx] = disp_rs2_tag;
      rs1_rdy_d[alloc_idx] = disp_rs1_rdy | byp1;
      rs2_rdy_d[alloc_idx] = disp_rs2_rdy | byp2;
      rs1_val_d[alloc_idx] = byp1 ? cdb_data : disp_rs1_val;
      rs2_val_d[alloc_idx] = byp2 ? cdb_data : disp_rs2_val;
    end

    if (flush) begin
      valid_d = '0;
    end
  end

  always_comb begin
    iss_valid_d  = iss_valid_q;
    iss_opcode_d = iss_opcode_q;
    iss_btype_d  = iss_btype_q;
    iss_rs1_d    = iss_rs1_q;
    iss_rs2_d    = iss_rs2_q;
    iss_rob_d    = iss_rob_q;
    count_d      = count_q + CNT_W'(accept) - CNT_W'(move);

    if (flush) begin
      iss_valid_d = 1'b0;
      count_d     = '0;
    end else if (load) begin
      iss_valid_d = sel_found;
      if (sel_found) begin
        iss_opcode_d = opcode_q[sel_idx];
        iss_btype_d  = btype_q[sel_idx];
        iss_rs1_d    = rs1_val_q[sel_idx];
        iss_rs2_d    = rs2_val_q[sel_idx];
        iss_rob_d    = rob_q[sel_idx];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= '0;
      rs1_rdy_q <= '0;
      rs2_rdy_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        opcode_q[i]  <= '0;
        btype_q[i]   <= '0;
        rob_q[i]     <= '0;
        rs1_tag_q[i] <= '0;
        rs2_tag_q[i] <= '0;
        rs1_val_q[i] <= '0;
        rs2_val_q[i] <= '0;
      end
      count_q      <= '0;
      iss_valid_q  <= 1'b0;
      iss_opcode_q <= '0;
      iss_btype_q  <= '0;
      iss_rs1_q    <= '0;
      iss_rs2_q    <= '0;
      iss_rob_q    <= '0;
    end else begin
      valid_q      <= valid_d;
      rs1_rdy_q    <= rs1_rdy_d;
      rs2_rdy_q    <= rs2_rdy_d;
      opcode_q     <= opcode_d;
      btype_q      <= btype_d;
      rob_q        <= rob_d;
      rs1_tag_q    <= rs1_tag_d;
      rs2_tag_q    <= rs2_tag_d;
      rs1_val_q    <= rs1_val_d;
      rs2_val_q    <= rs2_val_d;
      count_q      <= count_d;
      iss_valid_q  <= iss_valid_d;
      iss_opcode_q <= iss_opcode_d;
      iss_btype_q  <= iss_btype_d;
      iss_rs1_q    <= iss_rs1_d;
      iss_rs2_q    <= iss_rs2_d;
      iss_rob_q    <= iss_rob_d;
    end
  end

  assign iss_valid       = iss_valid_q;
  assign iss_opcode      = iss_opcode_q;
  assign iss_branch_type = iss_btype_q;
  assign iss_rs1         = iss_rs1_q;
  assign iss_rs2         = iss_rs2_q;
  assign iss_rob_tag     = iss_rob_q;
  assign count           = count_q;

endmodule

// File: tb/tb_rsvs_issue.sv
// Bench for rsvs_issue: directed scenarios plus randomized traffic against a slot-array model.
module tb_rsvs_issue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int TAG_W = 6;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic disp_valid, disp_ready;
  logic [4:0] disp_opcode;
  logic [2:0] disp_branch_type;
  logic [TAG_W-1:0] disp_rob_tag, disp_rs1_tag, disp_rs2_tag;
  logic disp_rs1_rdy, disp_rs2_rdy;
  logic [XLEN-1:0] disp_rs1_val, disp_rs2_val;
  logic cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0] cdb_data;
  logic iss_valid, iss_ready;
  logic [4:0] iss_opcode;
  logic [2:0] iss_branch_type;
  logic [XLEN-1:0] iss_rs1, iss_rs2;
  logic [TAG_W-1:0] iss_rob_tag;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rsvs_issue #(.XLEN(XLEN), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_opcode(disp_opcode),
    .disp_branch_type(disp_branch_type), .disp_rob_tag(disp_rob_tag),
    .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
    .disp_rs1_tag(disp_rs1_tag), .disp_rs2_tag(disp_rs2_tag),
    .disp_rs1_val(disp_rs1_val), .disp_rs2_val(disp_rs2_val),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_opcode(iss_opcode),
    .iss_branch_type(iss_branch_type), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_rob_tag(iss_rob_tag), .count(count)
  );

  typedef struct {
    bit v;
    logic [4:0] op;
    logic [2:0] bt;
    logic [TAG_W-1:0] rob;
    bit r1, r2;
    logic [TAG_W-1:0] t1, t2;
    logic [XLEN-1:0] v1, v2;
  } ent_t;

  ent_t m_ent[DEPTH];
  ent_t m_iss;
  bit   m_iss_v;
  int   m_count;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_valid = 1'b0;
    cdb_valid  = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic disp(input logic [4:0] op, input logic [TAG_W-1:0] rob,
                      input logic r1, input logic [TAG_W-1:0] t1, input logic [XLEN-1:0] v1,
                      input logic r2, input logic [TAG_W-1:0] t2, input logic [XLEN-1:0] v2);
    disp_valid       = 1'b1;
    disp_opcode      = op;
    disp_branch_type = 3'd2;
    disp_rob_tag     = rob;
    disp_rs1_rdy     = r1;
    disp_rs1_tag     = t1;
    disp_rs1_val     = v1;
    disp_rs2_rdy     = r2;
    disp_rs2_tag     = t2;
    disp_rs2_val     = v2;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_ent[i].v = 0;
    m_iss_v = 0;
    m_count = 0;
  endtask

  // Advance the model one clock using the inputs currently presented.
  task automatic model_step();
    ent_t n[DEPTH];
    int sel, alloc;
    bit load, acc;
    n = m_ent;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) n[i].v = 0;
      m_iss_v = 0;
      m_count = 0;
    end else begin
      sel = -1;
      alloc = -1;
      for (int i = 0; i < DEPTH; i++) begin
        if (sel < 0 && m_ent[i].v && m_ent[i].r1 && m_ent[i].r2) sel = i;
        if (alloc < 0 && !m_ent[i].v) alloc = i;
      end
      acc  = disp_valid && (m_count != DEPTH);
      load = !m_iss_v || iss_ready;
      for (int i = 0; i < DEPTH; i++) begin
        if (n[i].v && cdb_valid && !n[i].r1 && n[i].t1 == cdb_tag) begin
          n[i].r1 = 1; n[i].v1 = cdb_data;
        end
        if (n[i].v && cdb_valid && !n[i].r2 && n[i].t2 == cdb_tag) begin
          n[i].r2 = 1; n[i].v2 = cdb_data;
        end
      end
      if (load) begin
        if (sel >= 0) begin
          m_iss   = m_ent[sel];
          m_iss_v = 1;
          n[sel].v = 0;
          m_count--;
        end else begin
          m_iss_v = 0;
        end
      end
      if (acc) begin
        n[alloc].v   = 1;
        n[alloc].op  = disp_opcode;
        n[alloc].bt  = disp_branch_type;
        n[alloc].rob = disp_rob_tag;
        n[alloc].t1  = disp_rs1_tag;
        n[alloc].t2  = disp_rs2_tag;
        n[alloc].r1  = disp_rs1_rdy || (cdb_valid && cdb_tag == disp_rs1_tag);
        n[alloc].r2  = disp_rs2_rdy || (cdb_valid && cdb_tag == disp_rs2_tag);
        n[alloc].v1  = disp_rs1_rdy ? disp_rs1_val : cdb_data;
        n[alloc].v2  = disp_rs2_rdy ? disp_rs2_val : cdb_data;
        m_count++;
      end
    end
    m_ent = n;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (iss_valid !== 1'b0 || count !== 3'd0 || disp_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctrl: iss_valid=%b count=%0d disp_ready=%b, want 0/0/1",
               iss_valid, count, disp_ready);
    end
    checks++;
    if (iss_rs1 !== 32'h0 || iss_rs2 !== 32'h0 || iss_opcode !== 5'h0 ||
        iss_branch_type !== 3'h0 || iss_rob_tag !== 6'h0) begin
      errors++;
      $display("FAIL reset_data: rs1=%h rs2=%h op=%h bt=%h rob=%h, want all 0",
               iss_rs1, iss_rs2, iss_opcode, iss_branch_type, iss_rob_tag);
    end
  endtask

  task automatic test_ready_dispatch();
    iss_ready = 1'b1;
    disp(5'h03, 6'h01, 1'b1, 6'h0, 32'h10, 1'b1, 6'h0, 32'h20);
    tick();
    idle();
    checks++;
    if (count !== 3'd1 || iss_valid !== 1'b0) begin
      errors++;
      $display("FAIL ready_e1: count=%0d iss_valid=%b, want 1/0", count, iss_valid);
    end
    tick();
    checks++;
    if (iss_valid !== 1'b1 || iss_rs1 !== 32'h10 || iss_rs2 !== 32'h20 ||
        iss_opcode !== 5'h03 || count !== 3'd0) begin
      errors++;
      $display("FAIL ready_issue: v=%b rs1=%h rs2=%h op=%h count=%0d, want 1/10/20/03/0",
               iss_valid, iss_rs1, iss_rs2, iss_opcode, count);
    end
    tick();
    checks++;
    if (iss_valid !== 1'b0) begin
      errors++;
      $display("FAIL ready_drain: iss_valid=%b, want 0", iss_valid);
    end
  endtask

  task automatic test_wakeup();
    iss_ready = 1'b1;
    disp(5'h04, 6'h09, 1'b0, 6'h05, 32'h0, 1'b1, 6'h0, 32'h2);
    tick();
    idle();
    tick();
    tick();
    checks++;
    if (iss_valid !== 1'b0 || count !== 3'd1) begin
      errors++;
      $display("FAIL wake_wait: iss_valid=%b count=%0d, want 0/1", iss_valid, count);
    end
    cdb_valid = 1'b1;
    cdb_tag   = 6'h05;
    cdb_data  = 32'hDEAD;
    tick();
    cdb_valid = 1'b0;
    checks++;
    if (iss_valid !== 1'b0) begin
      errors++;
      $display("FAIL wake_early: iss_valid=%b, want 0", iss_valid);
    end
    tick();
    checks++;
    if (iss_valid !== 1'b1 || iss_rs1 !== 32'hDEAD || iss_rob_tag !== 6'h09 ||
        iss_rs2 !== 32'h2) begin
      errors++;
      $display("FAIL wake_issue: v=%b rs1=%h rs2=%h rob=%h, want 1/dead/2/09",
               iss_valid, iss_rs1, iss_rs2, iss_rob_tag);
    end
    tick();
    disp(5'h05, 6'h0C, 1'b0, 6'h07, 32'h0, 1'b1, 6'h0, 32'h3);
    cdb_valid = 1'b1;
    cdb_tag   = 6'h07;
    cdb_data  = 32'hBEEF;
    tick();
    idle();
    tick();
    checks++;
    if (iss_valid !== 1'b1 || iss_rs1 !== 32'hBEEF || iss_rob_tag !== 6'h0C) begin
      errors++;
      $display("FAIL bypass_issue: v=%b rs1=%h rob=%h, want 1/beef/0c",
               iss_valid, iss_rs1, iss_rob_tag);
    end
    tick();
  endtask

  task automatic test_full();
    iss_ready = 1'b0;
    disp(5'h01, 6'd1, 1'b1, 6'h0, 32'h100, 1'b1, 6'h0, 32'h200);
    tick();
    idle();
    tick();
    for (int k = 2; k <= 5; k++) begin
      disp(5'h01, 6'(k), 1'b1, 6'h0, 32'(k), 1'b1, 6'h0, 32'h0);
      tick();
    end
    checks++;
    if (count !== 3'd4 || disp_ready !== 1'b0 || iss_valid !== 1'b1 || iss_rob_tag !== 6'd1) begin
      errors++;
      $display("FAIL full_state: count=%0d disp_ready=%b v=%b rob=%0d, want 4/0/1/1",
               count, disp_ready, iss_valid, iss_rob_tag);
    end
    disp(5'h01, 6'd6, 1'b1, 6'h0, 32'h6, 1'b1, 6'h0, 32'h0);
    tick();
    idle();
    checks++;
    if (count !== 3'd4 || iss_rob_tag !== 6'd1) begin
      errors++;
      $display("FAIL full_ignore: count=%0d rob=%0d, want 4/1", count, iss_rob_tag);
    end
    iss_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      tick();
      checks++;
      if (iss_valid !== 1'b1 || iss_rob_tag !== 6'(k)) begin
        errors++;
        $display("FAIL full_order: v=%b rob=%0d, want 1/%0d", iss_valid, iss_rob_tag, k);
      end
    end
    tick();
    checks++;
    if (iss_valid !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("FAIL full_drain: v=%b count=%0d, want 0/0", iss_valid, count);
    end
  endtask

  task automatic test_select();
    iss_ready = 1'b1;
    disp(5'h02, 6'h0A, 1'b0, 6'h11, 32'h0, 1'b1, 6'h0, 32'h1);
    tick();
    disp(5'h02, 6'h0B, 1'b1, 6'h0, 32'h5, 1'b1, 6'h0, 32'h6);
    tick();
    idle();
    tick();
    checks++;
    if (iss_valid !== 1'b1 || iss_rob_tag !== 6'h0B) begin
      errors++;
      $display("FAIL select_first: v=%b rob=%h, want 1/0b", iss_valid, iss_rob_tag);
    end
    cdb_valid = 1'b1;
    cdb_tag   = 6'h11;
    cdb_data  = 32'h12345678;
    tick();
    cdb_valid = 1'b0;
    checks++;
    if (iss_valid !== 1'b0) begin
      errors++;
      $display("FAIL select_gap: v=%b, want 0", iss_valid);
    end
    tick();
    checks++;
    if (iss_valid !== 1'b1 || iss_rob_tag !== 6'h0A || iss_rs1 !== 32'h12345678) begin
      errors++;
      $display("FAIL select_second: v=%b rob=%h rs1=%h, want 1/0a/12345678",
               iss_valid, iss_rob_tag, iss_rs1);
    end
    tick();
  endtask

  task automatic test_flush();
    iss_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      disp(5'h07, 6'(k), 1'b1, 6'h0, 32'h1, 1'b1, 6'h0, 32'h1);
      tick();
    end
    checks++;
    if (count !== 3'd3 || iss_valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_setup: count=%0d v=%b, want 3/1", count, iss_valid);
    end
    disp(5'h07, 6'h3F, 1'b1, 6'h0, 32'h1, 1'b1, 6'h0, 32'h1);
    flush = 1'b1;
    tick();
    idle();
    checks++;
    if (count !== 3'd0 || iss_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_clear: count=%0d v=%b, want 0/0", count, iss_valid);
    end
    iss_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (iss_valid !== 1'b0 || count !== 3'd0) begin
        errors++;
        $display("FAIL flush_late: v=%b count=%0d, want 0/0", iss_valid, count);
      end
    end
  endtask

  task automatic test_async_reset();
    iss_ready = 1'b0;
    disp(5'h09, 6'h21, 1'b1, 6'h0, 32'h77, 1'b1, 6'h0, 32'h88);
    tick();
    tick();
    tick();
    idle();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (count !== 3'd0 || iss_valid !== 1'b0 || disp_ready !== 1'b1 || iss_rs1 !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: count=%0d v=%b disp_ready=%b rs1=%h, want 0/0/1/0",
               count, iss_valid, disp_ready, iss_rs1);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_random();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      disp_valid       = ($urandom_range(0, 99) < 60);
      disp_opcode      = 5'($urandom);
      disp_branch_type = 3'($urandom);
      disp_rob_tag     = 6'($urandom);
      disp_rs1_rdy     = ($urandom_range(0, 1) == 1);
      disp_rs2_rdy     = ($urandom_range(0, 1) == 1);
      disp_rs1_tag     = 6'($urandom_range(0, 7));
      disp_rs2_tag     = 6'($urandom_range(0, 7));
      disp_rs1_val     = $urandom;
      disp_rs2_val     = $urandom;
      cdb_valid        = ($urandom_range(0, 99) < 40);
      cdb_tag          = 6'($urandom_range(0, 9));
      cdb_data         = $urandom;
      iss_ready        = ($urandom_range(0, 99) < 70);
      flush            = ($urandom_range(0, 99) < 3);
      model_step();
      tick();
      checks++;
      if (iss_valid !== m_iss_v || count !== 3'(m_count) ||
          disp_ready !== (m_count != DEPTH)) begin
        errors++;
        $display("FAIL rand_ctrl cyc %0d: v=%b count=%0d rdy=%b, want %b/%0d/%b", c,
                 iss_valid, count, disp_ready, m_iss_v, m_count, m_count != DEPTH);
      end
      if (m_iss_v) begin
        checks++;
        if (iss_opcode !== m_iss.op || iss_branch_type !== m_iss.bt ||
            iss_rob_tag !== m_iss.rob || iss_rs1 !== m_iss.v1 || iss_rs2 !== m_iss.v2) begin
          errors++;
          $display("FAIL rand_data cyc %0d: op=%h bt=%h rob=%h rs1=%h rs2=%h, want %h/%h/%h/%h/%h",
                   c, iss_opcode, iss_branch_type, iss_rob_tag, iss_rs1, iss_rs2,
                   m_iss.op, m_iss.bt, m_iss.rob, m_iss.v1, m_iss.v2);
        end
      end
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    disp_valid = 1'b0;
    disp_opcode = '0;
    disp_branch_type = '0;
    disp_rob_tag = '0;
    disp_rs1_rdy = 1'b0;
    disp_rs2_rdy = 1'b0;
    disp_rs1_tag = '0;
    disp_rs2_tag = '0;
    disp_rs1_val = '0;
    disp_rs2_val = '0;
    cdb_valid = 1'b0;
    cdb_tag = '0;
    cdb_data = '0;
    iss_ready = 1'b1;
    test_reset();
    test_ready_dispatch();
    test_wakeup();
    test_full();
    test_select();
    test_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
